// File: rtl/alu_pkg.sv
// ALU pipeline shared definitions.
// Funct codes and flag bit positions.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath with N/Z/C/V flags.
// SLT/SLTU decode only when ALU_SLT_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic [5:0]       in_op,
  output logic [NBITS-1:0] r,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(NBITS);
  localparam int M   = NBITS - 1;

  logic [NBITS:0] sum;
  logic [NBITS:0] dif;
  logic [SHW-1:0] sh;
  logic           c;
  logic           v;

  // Decode funct, compute result and carry/overflow.
  always_comb begin
    sum     = {1'b0, in_a} + {1'b0, in_b};
    dif     = {1'b0, in_a} - {1'b0, in_b};
    sh      = in_b[SHW-1:0];
    r       = '0;
    c       = 1'b0;
    v       = 1'b0;
    illegal = 1'b0;
    unique case (in_op)
      OP_ADD: begin
        r = sum[M:0];
        c = sum[NBITS];
        v = (in_a[M] == in_b[M]) &&
            (sum[M] != in_a[M]);
      end
      OP_SUB: begin
        r = dif[M:0];
        c = !dif[NBITS];
        v = (in_a[M] != in_b[M]) &&
            (dif[M] != in_a[M]);
      end
      OP_AND: r = in_a & in_b;
      OP_OR:  r = in_a | in_b;
      OP_XOR: r = in_a ^ in_b;
      OP_NOR: r = ~(in_a | in_b);
      OP_SRA: r = $unsigned($signed(in_a) >>> sh);
      OP_SRL: r = in_a >> sh;
`ifdef ALU_SLT_EN
      OP_SLT:
        r = {{(NBITS-1){1'b0}},
             $signed(in_a) < $signed(in_b)};
      OP_SLTU:
        r = {{(NBITS-1){1'b0}}, in_a < in_b};
`endif
      default: illegal = 1'b1;
    endcase
    flags        = '0;
    flags[FLG_N] = r[M];
    flags[FLG_Z] = (r == '0);
    flags[FLG_C] = c;
    flags[FLG_V] = v;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU.
// Optional SLT/SLTU via the ALU_SLT_EN macro.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic [5:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_r,
  output logic [3:0]       out_flags,
  output logic             out_illegal
);

  logic             s1_valid;
  logic [NBITS-1:0] s1_a;
  logic [NBITS-1:0] s1_b;
  logic [5:0]       s1_op;
  logic             s2_adv;
  logic [NBITS-1:0] c_r;
  logic [3:0]       c_flags;
  logic             c_ill;

  assign s2_adv   = s1_valid & (!out_valid | out_ready);
  assign in_ready = !s1_valid | s2_adv;

  alu_core #(.NBITS(NBITS)) u_core (
    .in_a    (s1_a),
    .in_b    (s1_b),
    .in_op   (s1_op),
    .r       (c_r),
    .flags   (c_flags),
    .illegal (c_ill)
  );

  // S1: capture operands on input handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: register result, hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_r       <= '0;
      out_flags   <= '0;
      out_illegal <= 1'b0;
    end else if (s2_adv) begin
      out_valid   <= 1'b1;
      out_r       <= c_r;
      out_flags   <= c_flags;
      out_illegal <= c_ill;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (NBITS=8).
// Directed vectors; expected results hand-computed.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] f;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [5:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_r;
  logic [3:0] out_flags;
  logic       out_illegal;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc = 0;

  alu_pipe #(.NBITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_r       (out_r),
    .out_flags   (out_flags),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [5:0] op,
                       input logic [7:0] r,
                       input logic [3:0] f,
                       input logic       ill);
    int n;
    exp_t e;
    n = 0;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout op=%h got in_ready=0 want 1",
               op);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.r = r;
    e.f = f;
    e.ill = ill;
    q.push_back(e);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout left=%0d want 0",
               q.size());
      q.delete();
    end
  endtask

  // Monitor: compare head while valid, pop on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got r=%h want none",
                   out_r);
        end else begin
          e = q[0];
          if ({out_r, out_flags, out_illegal} !== e) begin
            errors++;
            $display("FAIL result got r=%h f=%b i=%b want r=%h f=%b i=%b",
                     out_r, out_flags, out_illegal,
                     e.r, e.f, e.ill);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int first;
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ov", {31'b0, out_valid}, 0);
    chk("rst_r", {24'b0, out_r}, 0);
    chk("rst_f", {28'b0, out_flags}, 0);
    chk("rst_ill", {31'b0, out_illegal}, 0);
    chk("rst_ird", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;

    issue(8'h7F, 8'h01, 6'b100000, 8'h80, 4'b1001, 0);
    @(negedge clk);
    chk("lat_c1", {31'b0, out_valid}, 0);
    @(negedge clk);
    chk("lat_c2", {31'b0, out_valid}, 1);
    @(posedge clk);
    #1;

    issue(8'h05, 8'h05, 6'b100010, 8'h00, 4'b0110, 0);
    issue(8'h00, 8'h01, 6'b100010, 8'hFF, 4'b1000, 0);
    issue(8'h90, 8'hE3, 6'b000011, 8'hF2, 4'b1000, 0);
    issue(8'h90, 8'h03, 6'b000010, 8'h12, 4'b0000, 0);
    issue(8'h90, 8'h00, 6'b000010, 8'h90, 4'b1000, 0);
    issue(8'h90, 8'h00, 6'b000011, 8'h90, 4'b1000, 0);
    issue(8'h12, 8'h34, 6'b111111, 8'h00, 4'b0100, 1);
    issue(8'hF0, 8'h3C, 6'b100100, 8'h30, 4'b0000, 0);
    issue(8'hF0, 8'h0F, 6'b100101, 8'hFF, 4'b1000, 0);
    issue(8'hAA, 8'hAA, 6'b100110, 8'h00, 4'b0100, 0);
    issue(8'h00, 8'h00, 6'b100111, 8'hFF, 4'b1000, 0);
    issue(8'hFF, 8'h01, 6'b100000, 8'h00, 4'b0110, 0);
    issue(8'h80, 8'h01, 6'b100010, 8'h7F, 4'b0011, 0);
`ifdef ALU_SLT_EN
    issue(8'hFF, 8'h01, 6'b101010, 8'h01, 4'b0000, 0);
    issue(8'hFF, 8'h01, 6'b101011, 8'h00, 4'b0100, 0);
`else
    issue(8'hFF, 8'h01, 6'b101010, 8'h00, 4'b0100, 1);
    issue(8'hFF, 8'h01, 6'b101011, 8'h00, 4'b0100, 1);
`endif
    drain();

    @(posedge clk);
    #1;
    issue(8'h01, 8'h02, 6'b100000, 8'h03, 4'b0000, 0);
    first = acc;
    issue(8'h03, 8'h04, 6'b100000, 8'h07, 4'b0000, 0);
    issue(8'h0F, 8'hF0, 6'b100100, 8'h00, 4'b0100, 0);
    issue(8'h0F, 8'hF0, 6'b100101, 8'hFF, 4'b1000, 0);
    chk("burst_span", acc - first, 3);
    drain();

    @(posedge clk);
    #1;
    fork
      begin
        issue(8'h10, 8'h01, 6'b100000, 8'h11, 4'b0000, 0);
        issue(8'h20, 8'h01, 6'b100000, 8'h21, 4'b0000, 0);
        issue(8'h30, 8'h01, 6'b100010, 8'h2F, 4'b0010, 0);
        issue(8'h40, 8'h0F, 6'b100100, 8'h00, 4'b0100, 0);
        issue(8'h50, 8'h0F, 6'b100101, 8'h5F, 4'b0000, 0);
        issue(8'h60, 8'h01, 6'b000010, 8'h30, 4'b0000, 0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("stall_ird", {31'b0, in_ready}, 0);
        chk("stall_ov", {31'b0, out_valid}, 1);
        chk("stall_q", q.size(), 2);
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(8'h01, 8'h01, 6'b100000, 8'h02, 4'b0000, 0);
    issue(8'h02, 8'h02, 6'b100000, 8'h04, 4'b0000, 0);
    chk("full_ird", {31'b0, in_ready}, 0);
    reset = 1'b1;
    q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_ov", {31'b0, out_valid}, 0);
    chk("mrst_r", {24'b0, out_r}, 0);
    chk("mrst_f", {28'b0, out_flags}, 0);
    chk("mrst_ill", {31'b0, out_illegal}, 0);
    chk("mrst_ird", {31'b0, in_ready}, 1);
    repeat (4) begin
      @(negedge clk);
      chk("mrst_nobeat", {31'b0, out_valid}, 0);
    end
    @(posedge clk);
    #1;
    issue(8'h02, 8'h03, 6'b100000, 8'h05, 4'b0000, 0);
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational datapath ALU, using the same 6-bit MIPS funct encoding.
- Adds a valid/ready handshake on input and output, full backpressure, status flags and an illegal-op indicator.
- Sits between the operand-loading front end (switch/UART capture) and the result display/transmit path.

Parameters:
- NBITS, 8, operand and result width (≥4).
- SHW, $clog2(NBITS), number of B bits used as the shift amount (derived localparam).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand triple is valid this cycle.
- in_ready  out  1  block accepts a triple this cycle.
- in_a  in  NBITS  operand A, signed.
- in_b  in  NBITS  operand B, signed.
- in_op  in  6  funct code.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_r  out  NBITS  result.
- out_flags  out  4  {N, Z, C, V}.
- out_illegal  out  1  the funct code was unsupported; out_r is 0.

Behaviour:
- **Interface decision:** one clock, `clk`; reset, `reset`, is synchronous and active-high.
- **Reset:** s1_valid=0, s2_valid=0, out_valid=0, out_r=0, out_flags=0, out_illegal=0. in_ready=1 in the first cycle after reset is deasserted.
- **Reset mid-operation:** discards all in-flight data; no output beat is produced.
- **Stage 1 (S1):** registers in_a, in_b and in_op on an input handshake (in_valid & in_ready).
- **Stage 2 (S2):** computes from the S1 registers and registers out_r, out_flags and out_illegal.
- **Latency:** 2 cycles from the accepting edge to out_valid, when there is no backpressure. Throughput is 1 op/cycle.
- **Advance rules:**
  - s2_adv = s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | s2_adv (combinational).
  - The output register holds data stable while out_valid & !out_ready.
  - No bubbles are inserted under continuous handshakes, and no beat is lost or duplicated.
- **Ops:**
  - ADD 100000: A+B.
  - SUB 100010: A-B.
  - AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise.
  - SRA 000011: A>>>B[SHW-1:0], arithmetic.
  - SRL 000010: A>>B[SHW-1:0], zero-fill.
  - The upper bits of B are ignored for shifts. A shift amount of 0 returns A.
- **Flags:**
  - N = r[NBITS-1]; Z = (r==0).
  - C = carry-out of an NBITS+1 sum for ADD; for SUB, C = NOT borrow (1 when A≥B unsigned).
  - V = signed overflow for ADD/SUB only.
  - C and V are 0 for all other ops.
- **Unsupported funct:** out_r=0, flags={0,1,0,0}, out_illegal=1. The beat still completes the handshake.
- **Wrap-around:** ADD/SUB wrap modulo 2^NBITS; the overflow is reported only via C/V.
- **Simultaneous events:** a beat may enter S1 while S1 moves to S2 and S2 retires in the same edge.

Optional Feature:
- **Macro:** ALU_SLT_EN.
- **Defined:**
  - SLT 101010: r = (A<B signed) ? 1 : 0.
  - SLTU 101011: r = (A<B unsigned) ? 1 : 0.
  - N=0, Z=!r, C=V=0.
- **Undefined:** 101010 and 101011 are treated as unsupported, giving out_illegal=1 and r=0.

Decomposition:
- **Package `alu_pkg`:** funct constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL, OP_SLT, OP_SLTU; flag bit indices FLG_N, FLG_Z, FLG_C, FLG_V.
- **Sub-module `alu_core`:** purely combinational (in_a, in_b, in_op → r, flags, illegal), instantiated between S1 and S2. The pipeline/handshake logic stays in alu_pipe.

Test Plan:
- NBITS=8, out_ready=1, single ADD 0x7F+0x01 → out_r=0x80, N=1, Z=0, C=0, V=1, out_valid exactly 2 cycles after accept.
- SUB 0x05-0x05 → out_r=0x00, Z=1, C=1, V=0. SUB 0x00-0x01 → out_r=0xFF, N=1, C=0.
- SRA 0x90 by B=0xE3 (shamt 3) → 0xF2. SRL 0x90 by B=0x03 → 0x12. B=0x00 → A unchanged.
- Stream 6 ops back-to-back, holding out_ready=0 for cycles 3-6:
  - in_ready drops after 2 beats are held.
  - out_r stays stable while stalled.
  - All 6 results emerge in order with none lost or duplicated.
- in_op=0x3F → out_r=0, out_illegal=1, Z=1. With ALU_SLT_EN: SLT 0xFF,0x01 → 1; SLTU 0xFF,0x01 → 0. Without the macro, op 101010 → out_illegal=1.
- Assert reset for 1 cycle while both stages are full → no out_valid beat afterwards, all outputs 0, in_ready=1 on the next cycle.
